// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer around an 8-bit barrel shift stage (0..7 per pass).
// Optional: SHIFT_SEQUENCER_ROR_MOD_EN reduces ROR amounts mod 8 at accept.
module shift_sequencer #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic [7:0]       sh_a,
    output logic [2:0]       sh_amt,
    input  logic [7:0]       sh_lsl,
    input  logic [7:0]       sh_lsr,
    input  logic [7:0]       sh_asr,
    input  logic [7:0]       sh_ror,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_zero,
    output logic             out_carry
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state;
    logic [7:0]       acc;
    logic [AMT_W-1:0] rem;
    logic [1:0]       op;
    logic             carry;
    logic             zero;

    logic [2:0]       chunk;
    logic [7:0]       res;
    logic             cbit;
    logic [AMT_W-1:0] eff_amt;
    logic             wrap;

    always_comb begin
        chunk = (rem >= AMT_W'(7)) ? 3'd7 : rem[2:0];
    end

    always_comb begin
        res = sh_lsl;
        unique case (op)
            OP_LSL: res = sh_lsl;
            OP_LSR: res = sh_lsr;
            OP_ASR: res = sh_asr;
            OP_ROR: res = sh_ror;
        endcase
    end

    // Last bit out: LSL loses acc[8-chunk], right shifts lose acc[chunk-1].
    always_comb begin
        cbit = 1'b0;
        unique case (op)
            OP_LSL: cbit = acc[3'd0 - chunk];
            OP_LSR: cbit = acc[chunk - 3'd1];
            OP_ASR: cbit = acc[chunk - 3'd1];
            OP_ROR: cbit = res[7];
        endcase
    end

`ifdef SHIFT_SEQUENCER_ROR_MOD_EN
    always_comb begin
        eff_amt = in_amt;
        wrap    = 1'b0;
        if (in_op == OP_ROR) begin
            eff_amt = AMT_W'(in_amt[2:0]);
            wrap    = (in_amt != '0) && (in_amt[2:0] == 3'd0);
        end
    end
`else
    always_comb begin
        eff_amt = in_amt;
        wrap    = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 8'h00;
            rem   <= '0;
            op    <= OP_LSL;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_data;
                        rem   <= eff_amt;
                        op    <= in_op;
                        carry <= wrap ? in_data[7] : 1'b0;
                        if (eff_amt == '0) begin
                            state <= DONE;
                            zero  <= (in_data == 8'h00);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= res;
                    carry <= cbit;
                    rem   <= rem - AMT_W'(chunk);
                    if (rem == AMT_W'(chunk)) begin
                        state <= DONE;
                        zero  <= (res == 8'h00);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        zero  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_zero  = zero;
    assign out_carry = carry;
    assign sh_a      = acc;
    assign sh_amt    = (state == RUN) ? chunk : 3'd0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift stage.
// Expected values below are worked out by hand from the command list.
module tb_shift_sequencer;

    localparam int AMT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_op;
    logic [7:0]       sh_a;
    logic [2:0]       sh_amt;
    logic [7:0]       sh_lsl;
    logic [7:0]       sh_lsr;
    logic [7:0]       sh_asr;
    logic [7:0]       sh_ror;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_zero;
    logic             out_carry;

    int n_assert = 0;
    int n_fail   = 0;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .sh_a      (sh_a),
        .sh_amt    (sh_amt),
        .sh_lsl    (sh_lsl),
        .sh_lsr    (sh_lsr),
        .sh_asr    (sh_asr),
        .sh_ror    (sh_ror),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dbl;
    always_comb begin
        dbl    = {sh_a, sh_a} >> sh_amt;
        sh_lsl = sh_a << sh_amt;
        sh_lsr = sh_a >> sh_amt;
        sh_asr = 8'($signed(sh_a) >>> sh_amt);
        sh_ror = dbl[7:0];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns cycles from accept edge to out_valid.
    task automatic issue(input logic [7:0] d, input int a, input logic [1:0] o,
                         output int lat);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = AMT_W'(a);
        in_op    = o;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = AMT_W'(a + 3);
        in_op    = ~o;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [7:0] d, input int a,
                       input logic [1:0] o, input logic [7:0] ed,
                       input logic ec, input logic ez, input int el);
        int lat;
        issue(d, a, o, lat);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_carry"}, out_carry, ec);
        chk({tag, "_zero"}, out_zero, ez);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int lat;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = '0;
        in_op     = 2'b00;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_sh_amt", sh_amt, 0);
        chk("rst_sh_a", sh_a, 8'h00);
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();

        run("lsl_81_1", 8'h81, 1, 2'b00, 8'h02, 1'b1, 1'b0, 1);
        run("asr_80_20", 8'h80, 20, 2'b10, 8'hFF, 1'b1, 1'b0, 3);
        run("lsr_f0_9", 8'hF0, 9, 2'b01, 8'h00, 1'b0, 1'b1, 2);
`ifdef SHIFT_SEQUENCER_ROR_MOD_EN
        run("ror_01_17", 8'h01, 17, 2'b11, 8'h80, 1'b1, 1'b0, 1);
        run("ror_a5_16", 8'hA5, 16, 2'b11, 8'hA5, 1'b1, 1'b0, 0);
`else
        run("ror_01_17", 8'h01, 17, 2'b11, 8'h80, 1'b1, 1'b0, 3);
        run("ror_a5_16", 8'hA5, 16, 2'b11, 8'hA5, 1'b1, 1'b0, 3);
`endif
        run("asr_40_31", 8'h40, 31, 2'b10, 8'h00, 1'b0, 1'b1, 5);

        issue(8'h0F, 4, 2'b00, lat);
        chk("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, 8'hF0);
            chk("bp_carry", out_carry, 0);
            chk("bp_zero", out_zero, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        run("amt0_3c", 8'h3C, 0, 2'b01, 8'h3C, 1'b0, 1'b0, 0);

        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_amt   = AMT_W'(31);
        in_op    = 2'b01;
        step();
        in_valid = 1'b0;
        chk("rr_run1_sh_amt", sh_amt, 7);
        chk("rr_run1_sh_a", sh_a, 8'hFF);
        step();
        chk("rr_run2_sh_a", sh_a, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_in_ready", in_ready, 1);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_out_data", out_data, 8'h00);
        chk("rr_out_zero", out_zero, 0);
        chk("rr_out_carry", out_carry, 0);
        chk("rr_sh_amt", sh_amt, 0);
        chk("rr_sh_a", sh_a, 8'h00);
        #3;
        rst_n = 1'b1;
        step();
        chk("rr_post_in_ready", in_ready, 1);
        chk("rr_post_out_valid", out_valid, 0);
        run("lsl_01_7", 8'h01, 7, 2'b00, 8'h80, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
